// File: rtl/alu_seq_pkg.sv
// Shared types for the 8085 ALU-group control sequencer: FSM states,
// opcode encodings and the accumulator write-back rule.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPERAND = 3'd1,
    ST_MEM_RD  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WB      = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBB = 3'd3;
  localparam logic [2:0] OP_ANA = 3'd4;
  localparam logic [2:0] OP_XRA = 3'd5;
  localparam logic [2:0] OP_ORA = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  // CMP only updates flags; every other ALU op also writes the accumulator.
  function automatic logic writes_acc(input logic [2:0] op);
    return (op != OP_CMP);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_wait_timer.sv
// Counts consecutive not-ready cycles of a memory read and flags the
// cycle on which the MAX_WAIT-th consecutive miss occurs.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);

  logic [W-1:0] count;

  assign expired = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control FSM for 8085 ALU-group instructions: operand fetch (register or
// memory with READY wait states and timeout), execute and write-back.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       use_mem,
  input  logic       mem_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       reg_oe,
  output logic       mem_rd,
  output logic       tmp_ld,
  output logic       acc_oe,
  output logic [2:0] alu_op,
  output logic       acc_ld,
  output logic       flag_ld
);

  state_t state;
  state_t state_next;
  logic   timer_clr;
  logic   timer_en;
  logic   expired;

  // The timer is held clear outside MEM_RD, so every read starts from zero.
  assign timer_clr = (state != ST_MEM_RD);
  assign timer_en  = (state == ST_MEM_RD) && !mem_ready;

  wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op <= OP_ADD;
    end else if (state == ST_IDLE && start) begin
      alu_op <= opcode;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = use_mem ? ST_MEM_RD : ST_OPERAND;
        end
      end
      ST_OPERAND: state_next = ST_EXEC;
      // A ready on the final allowed cycle still completes the read.
      ST_MEM_RD: begin
        if (mem_ready) begin
          state_next = ST_EXEC;
        end else if (expired) begin
          state_next = ST_ERR;
        end
      end
      ST_EXEC: state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    done    = 1'b0;
    err     = 1'b0;
    reg_oe  = 1'b0;
    mem_rd  = 1'b0;
    tmp_ld  = 1'b0;
    acc_oe  = 1'b0;
    acc_ld  = 1'b0;
    flag_ld = 1'b0;
    case (state)
      ST_OPERAND: begin
        reg_oe = 1'b1;
        tmp_ld = 1'b1;
      end
      ST_MEM_RD: begin
        mem_rd = 1'b1;
        tmp_ld = mem_ready;
      end
      ST_EXEC: acc_oe = 1'b1;
      ST_WB: begin
        flag_ld = 1'b1;
        acc_ld  = writes_acc(alu_op);
        done    = 1'b1;
      end
      ST_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a queue-based cycle model checked
// on every falling edge, plus directed scenarios with literal expectations.
module tb_alu_op_sequencer;

  localparam int MAX_WAIT = 15;

  // Output vector layout: busy done err reg_oe mem_rd tmp_ld acc_oe acc_ld flag_ld
  localparam logic [8:0] V_OPERAND = 9'b100101000;
  localparam logic [8:0] V_MEMRD   = 9'b100010000;
  localparam logic [8:0] V_TMP     = 9'b000001000;
  localparam logic [8:0] V_EXEC    = 9'b100000100;
  localparam logic [8:0] V_WB_ACC  = 9'b110000011;
  localparam logic [8:0] V_WB_CMP  = 9'b110000001;
  localparam logic [8:0] V_ERR     = 9'b111000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       use_mem = 1'b0;
  logic       mem_ready = 1'b0;
  logic       busy, done, err, reg_oe, mem_rd, tmp_ld, acc_oe, acc_ld, flag_ld;
  logic [2:0] alu_op;

  int tests = 0;
  int fails = 0;

  alu_op_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opcode   (opcode),
    .use_mem  (use_mem),
    .mem_ready(mem_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .reg_oe   (reg_oe),
    .mem_rd   (mem_rd),
    .tmp_ld   (tmp_ld),
    .acc_oe   (acc_oe),
    .alu_op   (alu_op),
    .acc_ld   (acc_ld),
    .flag_ld  (flag_ld)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and are sampled on the next one.
  task automatic applyStimulus(input logic s, input logic [2:0] op, input logic mem);
    @(posedge clk);
    #1;
    start   = s;
    opcode  = op;
    use_mem = mem;
  endtask

  // Cycle model: expected output vectors are queued per op; a memory read
  // stays open until READY or MAX_WAIT consecutive misses.
  logic [8:0] exp_q[$];
  logic       reading = 1'b0;
  int         m_waits = 0;
  logic [2:0] m_alu_op = 3'd0;
  logic [8:0] act_v, exp_v;

  always @(negedge clk) begin
    act_v = {busy, done, err, reg_oe, mem_rd, tmp_ld, acc_oe, acc_ld, flag_ld};
    if (rst) begin
      exp_q.delete();
      reading  = 1'b0;
      m_waits  = 0;
      m_alu_op = 3'd0;
      exp_v    = '0;
    end else if (exp_q.size() > 0) begin
      exp_v = exp_q[0];
    end else if (reading) begin
      exp_v = mem_ready ? (V_MEMRD | V_TMP) : V_MEMRD;
    end else begin
      exp_v = '0;
    end

    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("[TB] FAIL outputs @%0t: got %b, expected %b", $time, act_v, exp_v);
    end
    tests++;
    if (alu_op !== m_alu_op) begin
      fails++;
      $display("[TB] FAIL alu_op @%0t: got %0d, expected %0d", $time, alu_op, m_alu_op);
    end
    tests++;
    if ($countones({reg_oe, mem_rd, acc_oe}) > 1) begin
      fails++;
      $display("[TB] FAIL bus_exclusive @%0t: got %b, expected at most one high",
               $time, {reg_oe, mem_rd, acc_oe});
    end

    if (!rst) begin
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end else if (reading) begin
        if (mem_ready) begin
          reading = 1'b0;
          exp_q.push_back(V_EXEC);
          exp_q.push_back((m_alu_op == 3'd7) ? V_WB_CMP : V_WB_ACC);
        end else begin
          m_waits++;
          if (m_waits == MAX_WAIT) begin
            reading = 1'b0;
            exp_q.push_back(V_ERR);
          end
        end
      end else if (start) begin
        m_alu_op = opcode;
        if (use_mem) begin
          reading = 1'b1;
          m_waits = 0;
        end else begin
          exp_q.push_back(V_OPERAND);
          exp_q.push_back(V_EXEC);
          exp_q.push_back((opcode == 3'd7) ? V_WB_CMP : V_WB_ACC);
        end
      end
    end
  end

  // Issues one op from IDLE and observes it until done (bounded). ready_at is
  // the op-relative cycle from which mem_ready is driven high.
  task automatic measureOp(input logic [2:0] op, input logic mem, input int ready_at,
                           output int lat, output int rd_n, output int tmp_n,
                           output int err_n, output int acc_n, output int flag_n,
                           output int op_done);
    lat = -1; rd_n = 0; tmp_n = 0; err_n = 0; acc_n = 0; flag_n = 0; op_done = -1;
    applyStimulus(1'b1, op, mem);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      mem_ready = (k >= ready_at);
      #1;
      rd_n   += int'(mem_rd);
      tmp_n  += int'(tmp_ld);
      err_n  += int'(err);
      acc_n  += int'(acc_ld);
      flag_n += int'(flag_ld);
      if (done) begin
        lat     = k;
        op_done = int'(alu_op);
        break;
      end
    end
    mem_ready = 1'b0;
  endtask

  int lat, rd_n, tmp_n, err_n, acc_n, flag_n, op_done, done_n, busy_n;

  initial begin
    $display("[TB] start");
    #12;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_outputs", int'({done, err, reg_oe, mem_rd, tmp_ld, acc_oe, acc_ld, flag_ld}), 0);
    checkOutput("reset_alu_op", int'(alu_op), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD with register operand, cycle by cycle
    applyStimulus(1'b1, 3'd0, 1'b0);
    @(posedge clk); #1; start = 1'b0; #1;
    checkOutput("add_c1_regoe_tmpld", int'({reg_oe, tmp_ld, acc_oe}), 3'b110);
    @(posedge clk); #2;
    checkOutput("add_c2_accoe", int'({reg_oe, tmp_ld, acc_oe}), 3'b001);
    @(posedge clk); #2;
    checkOutput("add_c3_wb", int'({acc_ld, flag_ld, done, err}), 4'b1110);
    checkOutput("add_c3_alu_op", int'(alu_op), 0);
    @(posedge clk); #2;
    checkOutput("add_c4_idle", int'(busy), 0);

    // Every opcode with a register operand
    for (int op = 0; op < 8; op++) begin
      measureOp(3'(op), 1'b0, 0, lat, rd_n, tmp_n, err_n, acc_n, flag_n, op_done);
      checkOutput($sformatf("reg_op%0d_latency", op), lat, 3);
      checkOutput($sformatf("reg_op%0d_acc_ld", op), acc_n, (op == 7) ? 0 : 1);
      checkOutput($sformatf("reg_op%0d_flag_ld", op), flag_n, 1);
      checkOutput($sformatf("reg_op%0d_alu_op", op), op_done, op);
    end

    // SUB from memory, three wait states
    measureOp(3'd2, 1'b1, 4, lat, rd_n, tmp_n, err_n, acc_n, flag_n, op_done);
    checkOutput("mem3_latency", lat, 6);
    checkOutput("mem3_mem_rd_cycles", rd_n, 4);
    checkOutput("mem3_tmp_ld_cycles", tmp_n, 1);
    checkOutput("mem3_err", err_n, 0);
    checkOutput("mem3_acc_ld", acc_n, 1);

    // Memory never ready: timeout
    measureOp(3'd0, 1'b1, 1000, lat, rd_n, tmp_n, err_n, acc_n, flag_n, op_done);
    checkOutput("timeout_latency", lat, MAX_WAIT + 1);
    checkOutput("timeout_mem_rd_cycles", rd_n, MAX_WAIT);
    checkOutput("timeout_err", err_n, 1);
    checkOutput("timeout_tmp_ld", tmp_n, 0);
    checkOutput("timeout_acc_ld", acc_n, 0);
    checkOutput("timeout_flag_ld", flag_n, 0);

    // Ready on the last allowed cycle wins over the timeout
    measureOp(3'd5, 1'b1, MAX_WAIT, lat, rd_n, tmp_n, err_n, acc_n, flag_n, op_done);
    checkOutput("lastready_latency", lat, MAX_WAIT + 2);
    checkOutput("lastready_mem_rd_cycles", rd_n, MAX_WAIT);
    checkOutput("lastready_err", err_n, 0);
    checkOutput("lastready_flag_ld", flag_n, 1);

    // start pulsed during EXEC is ignored
    applyStimulus(1'b1, 3'd4, 1'b0);
    done_n = 0;
    busy_n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      start = (k == 2);
      #1;
      done_n += int'(done);
      busy_n += int'(busy);
    end
    checkOutput("ignored_start_done_count", done_n, 1);
    checkOutput("ignored_start_busy_cycles", busy_n, 3);

    // start held high re-issues after a single IDLE cycle
    applyStimulus(1'b1, 3'd1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) start = 1'b0;
      #1;
      if (k == 3) checkOutput("held_first_done", int'(done), 1);
      if (k == 4) checkOutput("held_idle_gap", int'(busy), 0);
      if (k == 5) checkOutput("held_second_operand", int'(reg_oe), 1);
      if (k == 7) checkOutput("held_second_done", int'(done), 1);
    end

    // Asynchronous reset in the middle of a memory read
    applyStimulus(1'b1, 3'd3, 1'b1);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_outputs", int'({done, err, reg_oe, mem_rd, tmp_ld, acc_oe, acc_ld, flag_ld}), 0);
    checkOutput("midreset_alu_op", int'(alu_op), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    measureOp(3'd6, 1'b0, 0, lat, rd_n, tmp_n, err_n, acc_n, flag_n, op_done);
    checkOutput("postreset_latency", lat, 3);
    checkOutput("postreset_alu_op", op_done, 6);

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control sequencer for the 8085 ALU-group instructions (ADD/ADC/SUB/SBB/ANA/XRA/ORA/CMP, register or memory operand). It sits between instruction decode and the datapath. On a start pulse it moves the operand onto the internal bus into the ALU temp register. It then enables the accumulator onto the ALU A-input and strobes accumulator/flag write-back. Memory-operand ops run a read handshake with READY wait states and a bounded wait timeout.

## Interface
- MAX_WAIT, 15: maximum consecutive not-ready cycles tolerated in a memory read; must be ≥1.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  op request; sampled only in IDLE.
- opcode  in  3  ALU op: 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 ANA, 5 XRA, 6 ORA, 7 CMP; captured with start.
- use_mem  in  1  1 = operand from memory (M), 0 = from register; captured with start.
- mem_ready  in  1  memory READY; data valid on bus when high during a read.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse at op end (success or error).
- err  out  1  one-cycle pulse with done on memory timeout.
- reg_oe  out  1  selected register drives internal bus.
- mem_rd  out  1  memory read strobe.
- tmp_ld  out  1  ALU temp register loads from bus.
- acc_oe  out  1  accumulator drives ALU A-input (accumulator `set`).
- alu_op  out  3  captured opcode, held stable for the whole op.
- acc_ld  out  1  accumulator loads ALU result.
- flag_ld  out  1  flag register loads ALU flags.

## Operation
- States: IDLE, OPERAND, MEM_RD, EXEC, WB, ERR.
- IDLE: start=1 → capture opcode/use_mem; next state MEM_RD if use_mem else OPERAND. start=0 → stay.
- start outside IDLE is ignored. It is not queued.
- OPERAND (1 cycle): reg_oe=1, tmp_ld=1 → EXEC.
- MEM_RD: mem_rd=1.
  - mem_ready=1 → tmp_ld=1 (combinational, same cycle) → EXEC.
  - mem_ready=0 → increment wait count.
  - If mem_ready=0 and count==MAX_WAIT-1 → ERR.
  - The wait count clears on MEM_RD entry.
  - If ready and the final count coincide, ready wins.
- EXEC (1 cycle): acc_oe=1 → WB.
- WB (1 cycle): flag_ld=1; acc_ld=1 unless alu_op==7 (CMP: flags only); done=1 → IDLE.
- ERR (1 cycle): done=1, err=1; no tmp_ld/acc_ld/flag_ld → IDLE.
- Invariant: reg_oe, mem_rd, acc_oe are mutually exclusive in every cycle.
- alu_op holds its last captured value in IDLE.

## Timing
- Outputs are Moore decodes of the state register, except tmp_ld in MEM_RD (Mealy on mem_ready).
- Register op: start edge E0; OPERAND in cycle after E0, EXEC after E1, WB (done) after E2; IDLE after E3. Latency start→done = 3 cycles.
- Memory op with w not-ready cycles (w < MAX_WAIT): start→done = 3 + w cycles.
- Timeout: MEM_RD lasts exactly MAX_WAIT cycles, then ERR. start→done = MAX_WAIT + 1 cycles.
- Minimum issue interval: 4 cycles. start held high continuously re-issues immediately on return to IDLE.
- Reset, asynchronous at any time including mid-op:
  - State → IDLE, wait count → 0, alu_op → 0.
  - All 1-bit outputs → 0 immediately.
  - No partial write-back completes.

## Structure
- Package alu_seq_pkg holds:
  - State enum.
  - Opcode constants OP_ADD..OP_CMP.
  - Helper function writes_acc(op) (false only for OP_CMP).
- Sub-module wait_timer (parameter MAX_WAIT):
  - Inputs clr, en.
  - Output expired, asserted when count==MAX_WAIT-1 and en.
  - Counter width $clog2(MAX_WAIT+1).
- FSM and output decode live in alu_op_sequencer.

## Test plan
- Reset, then start=1, opcode=0 (ADD), use_mem=0:
  - Cycle 1: reg_oe=tmp_ld=1.
  - Cycle 2: acc_oe=1.
  - Cycle 3: acc_ld=flag_ld=done=1, alu_op=0.
  - Cycle 4: IDLE, busy=0.
- opcode=7 (CMP), register operand → WB has flag_ld=1, acc_ld=0, done=1.
- opcode=2, use_mem=1, mem_ready low 3 cycles then high:
  - mem_rd high 4 cycles; tmp_ld only in the 4th.
  - done 6 cycles after start; err=0.
- use_mem=1, mem_ready held 0, MAX_WAIT=15:
  - mem_rd high exactly 15 cycles.
  - Then done=err=1 for one cycle; acc_ld and flag_ld never asserted.
  - mem_ready rising on the 15th cycle instead → EXEC, err=0.
- start pulsed during EXEC of a running op → ignored; exactly one done.
  - start held high → second op's OPERAND begins the cycle after IDLE.
- rst asserted mid-MEM_RD (async, between edges) → all outputs 0 immediately, busy=0.
  - After release, a new register op completes in 3 cycles.
  - Invariant check every cycle: no two of reg_oe/mem_rd/acc_oe high together.
